// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
// Shared definitions for the memory responder slice: word width, default
// geometry/timing constants and the responder state encoding.
// Optional feature macro used by this slice: MEM_RESPONDER_ERR_EN
// (enables access-error detection in mem_responder).
// -----------------------------------------------------------------------------
package mem_responder_pkg;

    localparam int WORD_W      = 32;
    localparam int DEF_DEPTH   = 256;
    localparam int DEF_WAIT    = 2;
    localparam int CNT_W       = 4;   // holds WAIT_CYCLES in 0..15

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage : mem_responder_pkg

// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
// Request/response bus between an initiator (master) and mem_responder (slave).
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. While
// rsp_valid is high, rsp_rdata and rsp_err are held stable. rsp_err is only
// meaningful while rsp_valid is high.
//
// Signals:
//   req_valid  master->slave  request present
//   req_write  master->slave  1=store, 0=load/fetch
//   req_addr   master->slave  byte address
//   req_wdata  master->slave  store data
//   req_ready  slave->master  request can be accepted this cycle
//   rsp_valid  slave->master  response available
//   rsp_rdata  slave->master  load data / stored word
//   rsp_err    slave->master  access error flag
//   rsp_ready  master->slave  response consumed
// -----------------------------------------------------------------------------
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic              req_valid;
    logic              req_write;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_ready;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface : mem_responder_if

// File: rtl/mem_responder_mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// Single-port synchronous RAM, DEPTH words of WORD_W bits, registered read.
// A write is write-first: the read register returns the word being written.
// Only the read register is reset; the array contents survive reset.
//
// Ports:
//   clk      clock
//   rst_n    async active-low reset (read register only)
//   en_i     access enable; read register updates only when set
//   we_i     write enable (qualified by en_i)
//   addr_i   word index
//   wdata_i  write data
//   rdata_o  registered read data
// -----------------------------------------------------------------------------
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= we_i ? wdata_i : mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : mem_array

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory responder: accepts one request at a time, waits WAIT_CYCLES extra
// cycles, commits the access to a DEPTH-word array, then presents the
// response until the initiator consumes it.
//
// Optional macro MEM_RESPONDER_ERR_EN: flags misaligned addresses or
// addresses with bits set above the word index; errored stores do not write
// and errored responses return zero data. Without it rsp_err is always 0 and
// the low two address bits are ignored.
//
// Ports:
//   clk      clock
//   rst_n    async active-low reset
//   bus      mem_responder_if.slave request/response bus
//   state_o  current FSM state (debug)
// -----------------------------------------------------------------------------
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_CYCLES = DEF_WAIT
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_responder_if.slave   bus,
    output state_t           state_o
);

    localparam int AW = $clog2(DEPTH);

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                wr_q;
    logic [AW-1:0]       idx_q;
    logic [WORD_W-1:0]   wdata_q;
    logic                err_q;      // error of the request in flight
    logic                rsp_err_q;  // error of the presented response

    logic                accept;
    logic                commit;
    logic                req_err;
    logic [WORD_W-1:0]   ram_rdata;

`ifdef MEM_RESPONDER_ERR_EN
    assign req_err = (bus.req_addr[1:0] != 2'b00) ||
                     ((bus.req_addr >> (AW + 2)) != '0);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.req_addr[WORD_W-1:AW+2], bus.req_addr[1:0]};
    assign req_err = 1'b0;
`endif

    assign accept = (state_q == ST_IDLE) && bus.req_valid;
    assign commit = (state_q == ST_BUSY) && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        wr_q    <= bus.req_write;
                        idx_q   <= bus.req_addr[AW+1:2];
                        wdata_q <= bus.req_wdata;
                        err_q   <= req_err;
                        cnt_q   <= CNT_W'(WAIT_CYCLES);
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        // The array access itself happens in mem_array on this edge.
                        rsp_err_q <= err_q;
                        state_q   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Read register only updates on the commit edge, so rsp_rdata is held
    // stable for the whole RESP phase.
    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (commit),
        .we_i    (commit && wr_q && !err_q),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_err_q ? '0 : ram_rdata;
    assign state_o       = state_q;

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Directed plus randomized checks of mem_responder against an array model.
// -----------------------------------------------------------------------------
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int DEPTH = 256;
    localparam int WAIT  = 2;

    logic   clk;
    logic   rst_n;
    state_t state_dbg;
    int     checks;
    int     failures;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_q [$];

    mem_responder_if bus_if ();

    mem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus_if.slave),
        .state_o (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: error and target word derived from the address rules.
    function automatic bit addr_is_err(input logic [31:0] addr);
`ifdef MEM_RESPONDER_ERR_EN
        return (addr % 4 != 0) || (longint'(addr) >= longint'(DEPTH) * 4);
`else
        return 1'b0;
`endif
    endfunction

    // One complete transaction: issue, check latency and ready, hold the
    // response for 'hold' cycles checking stability, then release.
    task automatic do_txn(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input int hold);
        int          idx;
        bit          err;
        int          n;
        logic [31:0] exp_d;
        logic [31:0] first_d;
        idx = int'((addr / 4) % DEPTH);
        err = addr_is_err(addr);
        if (err) exp_d = 32'd0;
        else if (wr) exp_d = wd;
        else exp_d = model_mem[idx];
        if (wr && !err) model_mem[idx] = wd;
        exp_q.push_back(exp_d);

        check("req_ready_before", 32'(bus_if.req_ready), 32'd1);
        bus_if.req_valid = 1'b1;
        bus_if.req_write = wr;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wd;
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
        bus_if.req_write = $urandom_range(0, 1);
        bus_if.req_addr  = $urandom;
        bus_if.req_wdata = $urandom;
        n = 0;
        while (bus_if.rsp_valid !== 1'b1 && n < 40) begin
            check("req_ready_busy", 32'(bus_if.req_ready), 32'd0);
            // Requests offered while busy must be ignored.
            bus_if.req_valid = $urandom_range(0, 1);
            @(posedge clk); #1;
            n++;
        end
        bus_if.req_valid = 1'b0;
        check("latency", 32'(n), 32'(WAIT + 1));
        check("req_ready_resp", 32'(bus_if.req_ready), 32'd0);
        check("rsp_rdata", bus_if.rsp_rdata, exp_q.pop_front());
        check("rsp_err", 32'(bus_if.rsp_err), 32'(err));
        first_d = bus_if.rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(bus_if.rsp_valid), 32'd1);
            check("hold_rdata", bus_if.rsp_rdata, first_d);
        end
        bus_if.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.rsp_ready = 1'b0;
        check("release_valid", 32'(bus_if.rsp_valid), 32'd0);
        check("release_ready", 32'(bus_if.req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus_if.req_valid = 1'b0;
        bus_if.req_write = 1'b0;
        bus_if.req_addr  = '0;
        bus_if.req_wdata = '0;
        bus_if.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus_if.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus_if.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(bus_if.rsp_err), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill every word so later loads have known contents.
        for (int i = 0; i < DEPTH; i++) begin
            do_txn(1'b1, 32'(i * 4), $urandom, 0);
        end

        // Store then load of the same word, with a long response stall.
        do_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 0);
        do_txn(1'b0, 32'h10, 32'h0, 5);

        // Misaligned store: errors with the macro, writes word 8 without.
        do_txn(1'b1, 32'h22, 32'hA5A5_5A5A, 1);
        do_txn(1'b0, 32'h20, 32'h0, 0);

        // Address above the array: wraps to word 0 (or errors with the macro).
        do_txn(1'b0, 32'h400, 32'h0, 0);

        // Reset one cycle into a store: the store must be abandoned.
        check("pre_rst_ready", 32'(bus_if.req_ready), 32'd1);
        bus_if.req_valid = 1'b1;
        bus_if.req_write = 1'b1;
        bus_if.req_addr  = 32'h20;
        bus_if.req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(bus_if.req_ready), 32'd1);
        check("mid_rst_valid", 32'(bus_if.rsp_valid), 32'd0);
        check("mid_rst_rdata", bus_if.rsp_rdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(bus_if.req_ready), 32'd1);
        do_txn(1'b0, 32'h20, 32'h0, 0);

        // Randomized traffic mixing in-range, misaligned and out-of-range addresses.
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 3))
                0:       a = $urandom;
                1:       a = 32'($urandom_range(0, DEPTH * 4 - 1));
                default: a = 32'($urandom_range(0, DEPTH - 1) * 4);
            endcase
            do_txn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_responder
